mem_word_reader: RTL and testbench
==================================

# mem_word_reader

Host-side reader for the G-15 memory lines: accepts a line/word read request, waits for the requested word to come around on the recirculating serial line, captures its 29 bits synchronously with the drum bit clock, and returns the word as a parallel value over a valid/ready handshake. It sits beside the memory-line group, tapping its serial outputs M0–M3 and M20 without disturbing them. It is used by the front-panel/debug path to inspect drum contents.

## Interface
- No parameters; word length fixed at 29 bits, long lines 108 words, M20 4 words.
- CLOCK  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted = 0).
- BIT_EN  in  1  one-CLOCK strobe per drum bit time; all sampling and counting are qualified by it.
- T0  in  1  high during bit time 0 of every word time.
- WORD_TIME  in  7  current word time 0..107, stable across a word.
- M0, M1, M2, M3, M20  in  1 each  serial memory-line data; first bit of a word at T0.
- req_valid  in  1  read request present.
- req_line  in  3  0–3 select M0–M3, 4 selects M20, 5–7 invalid.
- req_word  in  7  word address.
- req_ready  out  1  request accepted when req_valid & req_ready.
- abort  in  1  synchronous cancel of an outstanding read.
- rsp_valid  out  1  response present.
- rsp_data  out  29  captured word; first serial bit in bit 0.
- rsp_err  out  1  request was invalid; rsp_data = 0.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- busy  out  1  high in WAIT or SHIFT.

## Operation
- States: IDLE, WAIT, SHIFT, RESP. Reset state IDLE.
- IDLE: req_ready = 1. On accept, latch line and word. Invalid if req_line ≥ 5, or req_line ≤ 3 and req_word ≥ 108 -> RESP with rsp_err = 1, rsp_data = 0. Otherwise -> WAIT.
- M20 match uses req_word[1:0] against WORD_TIME[1:0]; higher req_word bits ignored, never an error.
- WAIT: on BIT_EN & T0 & word match, capture the selected line bit and enter SHIFT with bit count 1. A match whose T0 strobe already passed before the accept is missed; wait for the next revolution.
- SHIFT: each BIT_EN shifts the selected line bit into bit 28, existing contents right by one; after 29 captures total (bit times 0..28) -> RESP, rsp_err = 0.
- RESP: rsp_valid = 1, rsp_data/rsp_err stable until rsp_ready; on handshake -> IDLE.
- abort in WAIT or SHIFT -> IDLE next cycle, no response; abort ignored in IDLE and RESP.
- busy = (WAIT or SHIFT); req_ready = IDLE only; no request accepted in RESP.
- Memory-line signals are observed only; this block drives nothing toward the memory lines.

## Timing
- Reset values: req_ready = 1, rsp_valid = 0, rsp_data = 0, rsp_err = 0, busy = 0; shift register and count cleared.
- Reset asserted mid-operation: immediate return to IDLE, in-flight word discarded, no response.
- Invalid request: rsp_valid asserted the cycle after accept.
- Valid request: rsp_valid asserted the CLOCK after the BIT_EN of bit time 28 of the target word; worst case one full revolution (108 word times, 4 for M20) plus 29 bit times after accept.
- rsp_ready held high: handshake in first rsp_valid cycle, req_ready high next cycle; back-to-back accept possible one cycle later.
- BIT_EN cycles without T0 in WAIT, or CLOCK cycles without BIT_EN in SHIFT: no state change.
- Line select and word are latched at accept; later changes to req_* have no effect.

## Test plan
- Write 0x0ABCDEF pattern at M1 word 5 in the line model; request line 1 word 5 -> rsp_data = 0x0ABCDEF, rsp_err = 0, rsp_valid one CLOCK after bit time 28 of word time 5.
- M20 holds 0x1FFFFFFF at word 2; request line 4 word 6 -> rsp_data = 0x1FFFFFFF captured at first WORD_TIME[1:0] = 2.
- Request line 6, and separately line 0 word 108 -> rsp_err = 1, rsp_data = 0 the next cycle; no WAIT entered.
- Accept request line 2 word 10 during bit time 3 of word time 10 -> no capture until word time 10 of the next revolution (108 word times later).
- rsp_ready low for 50 cycles in RESP -> rsp_valid and rsp_data stable, req_ready = 0, new req_valid ignored; raise rsp_ready -> IDLE next cycle.
- Drop rst at bit 15 of SHIFT, and separately pulse abort in WAIT -> all outputs at reset values, no rsp_valid; a new request then completes correctly.

Source files
------------

// File: rtl/mem_word_reader.sv
// Host-side reader for the recirculating memory lines: waits for the addressed word,
// shifts its 29 bits in on the drum bit strobe and returns it over a valid/ready pair.
module mem_word_reader (
   input  logic        CLOCK,
   input  logic        rst,
   input  logic        BIT_EN,
   input  logic        T0,
   input  logic [6:0]  WORD_TIME,
   input  logic        M0,
   input  logic        M1,
   input  logic        M2,
   input  logic        M3,
   input  logic        M20,
   input  logic        req_valid,
   input  logic [2:0]  req_line,
   input  logic [6:0]  req_word,
   output logic        req_ready,
   input  logic        abort,
   output logic        rsp_valid,
   output logic [28:0] rsp_data,
   output logic        rsp_err,
   input  logic        rsp_ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SHIFT,
      S_RESP
   } state_t;

   state_t      state_reg, state_next;
   logic [2:0]  line_reg, line_next;
   logic [6:0]  word_reg, word_next;
   logic [28:0] shift_reg, shift_next;
   logic [4:0]  count_reg, count_next;
   logic        err_reg, err_next;

   logic        sel_bit;
   logic        word_match;
   logic        req_invalid;

   always_comb begin
      sel_bit = 1'b0;
      case (line_reg)
         3'd0:    sel_bit = M0;
         3'd1:    sel_bit = M1;
         3'd2:    sel_bit = M2;
         3'd3:    sel_bit = M3;
         3'd4:    sel_bit = M20;
         default: sel_bit = 1'b0;
      endcase
   end

   // M20 is only four words long, so only the low two address bits take part.
   assign word_match  = (line_reg == 3'd4) ? (word_reg[1:0] == WORD_TIME[1:0])
                                           : (word_reg == WORD_TIME);
   assign req_invalid = (req_line >= 3'd5) || ((req_line <= 3'd3) && (req_word >= 7'd108));

   always_ff @(posedge CLOCK or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         line_reg  <= 3'd0;
         word_reg  <= 7'd0;
         shift_reg <= 29'd0;
         count_reg <= 5'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         line_reg  <= line_next;
         word_reg  <= word_next;
         shift_reg <= shift_next;
         count_reg <= count_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      line_next  = line_reg;
      word_next  = word_reg;
      shift_next = shift_reg;
      count_next = count_reg;
      err_next   = err_reg;
      case (state_reg)
         S_IDLE: begin
            if (req_valid) begin
               line_next  = req_line;
               word_next  = req_word;
               shift_next = 29'd0;
               count_next = 5'd0;
               err_next   = req_invalid;
               state_next = req_invalid ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort) begin
               shift_next = 29'd0;
               count_next = 5'd0;
               state_next = S_IDLE;
            end else if (BIT_EN && T0 && word_match) begin
               shift_next = {sel_bit, shift_reg[28:1]};
               count_next = 5'd1;
               state_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               shift_next = 29'd0;
               count_next = 5'd0;
               state_next = S_IDLE;
            end else if (BIT_EN) begin
               // First serial bit ends up in bit 0 after all 29 shifts.
               shift_next = {sel_bit, shift_reg[28:1]};
               count_next = count_reg + 5'd1;
               if (count_reg == 5'd28) begin
                  count_next = 5'd0;
                  state_next = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               shift_next = 29'd0;
               err_next   = 1'b0;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign req_ready = (state_reg == S_IDLE);
   assign rsp_valid = (state_reg == S_RESP);
   assign busy      = (state_reg == S_WAIT) || (state_reg == S_SHIFT);
   assign rsp_data  = shift_reg;
   assign rsp_err   = err_reg;

endmodule

// File: tb/tb_mem_word_reader.sv
// Directed bench for mem_word_reader: a drum model recirculates four long lines and M20,
// and each read is checked for data, error flag, response timing and handshake.
module tb_mem_word_reader;

   logic        CLOCK;
   logic        rst;
   logic        BIT_EN;
   logic        T0;
   logic [6:0]  WORD_TIME;
   logic        M0, M1, M2, M3, M20;
   logic        req_valid;
   logic [2:0]  req_line;
   logic [6:0]  req_word;
   logic        req_ready;
   logic        abort;
   logic        rsp_valid;
   logic [28:0] rsp_data;
   logic        rsp_err;
   logic        rsp_ready;
   logic        busy;

   mem_word_reader dut (
      .CLOCK     (CLOCK),
      .rst       (rst),
      .BIT_EN    (BIT_EN),
      .T0        (T0),
      .WORD_TIME (WORD_TIME),
      .M0        (M0),
      .M1        (M1),
      .M2        (M2),
      .M3        (M3),
      .M20       (M20),
      .req_valid (req_valid),
      .req_line  (req_line),
      .req_word  (req_word),
      .req_ready (req_ready),
      .abort     (abort),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rsp_ready (rsp_ready),
      .busy      (busy)
   );

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   logic [28:0] mem [0:3][0:107];
   logic [28:0] m20 [0:3];
   logic [4:0]  bit_t;
   logic [6:0]  word_t;
   int          rev;
   int          rsp_cycles;
   int          rsp_rev;
   int          vectors;
   int          miscompares;

   // Drum model: two CLOCKs per bit time, BIT_EN high in the second one.
   initial begin
      bit_t  = 5'd0;
      word_t = 7'd0;
      rev    = 0;
      BIT_EN = 1'b0;
      forever begin
         @(negedge CLOCK);
         if (BIT_EN) begin
            BIT_EN = 1'b0;
            if (bit_t == 5'd28) begin
               bit_t = 5'd0;
               if (word_t == 7'd107) begin
                  word_t = 7'd0;
                  rev    = rev + 1;
               end else begin
                  word_t = word_t + 7'd1;
               end
            end else begin
               bit_t = bit_t + 5'd1;
            end
         end else begin
            BIT_EN = 1'b1;
         end
         T0        = (bit_t == 5'd0);
         WORD_TIME = word_t;
         M0        = mem[0][word_t][bit_t];
         M1        = mem[1][word_t][bit_t];
         M2        = mem[2][word_t][bit_t];
         M3        = mem[3][word_t][bit_t];
         M20       = m20[word_t[1:0]][bit_t];
      end
   end

   initial rsp_cycles = 0;
   always @(negedge CLOCK) if (rsp_valid === 1'b1) rsp_cycles = rsp_cycles + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors = vectors + 1;
      if (got !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_drum(input logic [6:0] w, input logic [4:0] b);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 14000; i++) begin
         @(negedge CLOCK);
         #1;
         if (word_t == w && bit_t == b && !BIT_EN) begin
            hit = 1'b1;
            break;
         end
      end
      check("drum_wait", {31'd0, hit}, 32'd1);
   endtask

   task automatic do_req(input logic [2:0] l, input logic [6:0] w);
      req_valid = 1'b1;
      req_line  = l;
      req_word  = w;
      @(posedge CLOCK);
      #1;
      // Scramble the request bus: the accepted line/word must already be latched.
      req_valid = 1'b0;
      req_line  = 3'd7;
      req_word  = 7'h7f;
   endtask

   task automatic wait_rsp(output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 0; i < 14000; i++) begin
         if (rsp_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge CLOCK);
         #1;
         cyc = cyc + 1;
      end
   endtask

   task automatic run_read(input string tag, input logic [2:0] l, input logic [6:0] w,
                           input logic [28:0] exp_data, input logic [6:0] exp_word,
                           input logic [6:0] word_mask);
      bit ok;
      int cyc;
      do_req(l, w);
      wait_rsp(ok, cyc);
      rsp_rev = rev;
      check({tag, "_rsp_seen"}, {31'd0, ok}, 32'd1);
      if (ok) begin
         check({tag, "_data"}, {3'd0, rsp_data}, {3'd0, exp_data});
         check({tag, "_err"}, {31'd0, rsp_err}, 32'd0);
         check({tag, "_busy"}, {31'd0, busy}, 32'd0);
         check({tag, "_when"}, {19'd0, BIT_EN, bit_t, word_t & word_mask},
               {19'd0, 1'b1, 5'd28, exp_word});
         @(posedge CLOCK);
         #1;
         check({tag, "_ready_after"}, {30'd0, req_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});
      end
   endtask

   task automatic run_invalid(input string tag, input logic [2:0] l, input logic [6:0] w);
      bit ok;
      int cyc;
      do_req(l, w);
      wait_rsp(ok, cyc);
      check({tag, "_latency"}, {31'd0, ok}, 32'd1);
      check({tag, "_cycles"}, cyc, 0);
      check({tag, "_err"}, {31'd0, rsp_err}, 32'd1);
      check({tag, "_data"}, {3'd0, rsp_data}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      @(posedge CLOCK);
      #1;
      check({tag, "_ready_after"}, {30'd0, req_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
      check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, "_rsp_data"}, {3'd0, rsp_data}, 32'd0);
      check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int base;
      int bad;
      bit ok;
      int cyc;
      vectors     = 0;
      miscompares = 0;
      for (int l = 0; l < 4; l++)
         for (int w = 0; w < 108; w++)
            mem[l][w] = 29'((l + 1) * 32'h0123_4567 ^ w * 32'h0031_9F1B ^ 32'h0AA5_5A5);
      mem[1][5] = 29'h0ABCDEF;
      mem[0][5] = 29'h1234567;
      mem[2][5] = 29'h0F0F0F0;
      m20[0]    = 29'h0000001;
      m20[1]    = 29'h0555555;
      m20[2]    = 29'h1FFFFFFF;
      m20[3]    = 29'h0C0FFEE;

      rst       = 1'b0;
      req_valid = 1'b0;
      req_line  = 3'd0;
      req_word  = 7'd0;
      abort     = 1'b0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge CLOCK);
      #1;
      check_idle_outputs("reset");
      @(negedge CLOCK);
      #1;
      rst = 1'b1;
      @(posedge CLOCK);
      #1;

      run_read("m1_w5", 3'd1, 7'd5, 29'h0ABCDEF, 7'd5, 7'h7f);
      run_read("m20_w6", 3'd4, 7'd6, 29'h1FFFFFFF, 7'd2, 7'h03);
      run_read("m20_w126", 3'd4, 7'd126, 29'h1FFFFFFF, 7'd2, 7'h03);
      run_read("m20_w1", 3'd4, 7'd1, 29'h0555555, 7'd1, 7'h03);
      run_invalid("inv_line6", 3'd6, 7'd3);
      run_invalid("inv_w108", 3'd0, 7'd108);

      // Accepted after word 10 has already started: must wait a full revolution.
      wait_drum(7'd10, 5'd3);
      base = rev;
      run_read("late_w10", 3'd2, 7'd10, mem[2][10], 7'd10, 7'h7f);
      check("late_w10_rev", rsp_rev - base, 1);

      // Response held for 50 cycles while a new request is offered.
      rsp_ready = 1'b0;
      do_req(3'd3, 7'd0);
      wait_rsp(ok, cyc);
      check("hold_rsp_seen", {31'd0, ok}, 32'd1);
      req_valid = 1'b1;
      req_line  = 3'd1;
      req_word  = 7'd5;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge CLOCK);
         #1;
         if (rsp_valid !== 1'b1 || rsp_data !== mem[3][0] || rsp_err !== 1'b0 ||
             req_ready !== 1'b0 || busy !== 1'b0)
            bad = bad + 1;
      end
      check("hold_stable", bad, 0);
      rsp_ready = 1'b1;
      req_valid = 1'b0;
      @(posedge CLOCK);
      #1;
      check("hold_release", {30'd0, req_ready, rsp_valid}, {30'd0, 1'b1, 1'b0});
      @(posedge CLOCK);
      #1;
      check("hold_no_new_req", {31'd0, busy}, 32'd0);

      // Reset dropped in the middle of the shift.
      wait_drum(7'd19, 5'd0);
      do_req(3'd0, 7'd20);
      wait_drum(7'd20, 5'd15);
      check("rst_mid_busy", {31'd0, busy}, 32'd1);
      base = rsp_cycles;
      rst  = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      @(negedge CLOCK);
      #1;
      rst = 1'b1;
      wait_drum(7'd21, 5'd5);
      check("rst_mid_no_rsp", rsp_cycles - base, 0);
      run_read("after_rst", 3'd0, 7'd22, mem[0][22], 7'd22, 7'h7f);

      // Abort while waiting for the word.
      wait_drum(7'd30, 5'd0);
      do_req(3'd1, 7'd50);
      repeat (4) @(posedge CLOCK);
      #1;
      check("abort_busy", {31'd0, busy}, 32'd1);
      base  = rsp_cycles;
      abort = 1'b1;
      @(posedge CLOCK);
      #1;
      abort = 1'b0;
      check_idle_outputs("abort");
      wait_drum(7'd51, 5'd2);
      check("abort_no_rsp", rsp_cycles - base, 0);
      run_read("after_abort", 3'd1, 7'd60, mem[1][60], 7'd60, 7'h7f);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
